mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
// - Multi-cycle multiply/divide unit. Runs beside the single-cycle ALU in the EX stage and owns the HI/LO register pair.
// - Accepts one operation per start strobe, then holds busy for a fixed latency. The pipeline stalls any MDU instruction while (start | busy).
// - Commits the result to HI/LO at the end of that latency.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for mult/multu (and madd-family); must be >= 1
// - DIV_CYCLES   10  busy cycles for div/divu; must be >= 1
// PORTS
// - clk     input   1   clock, rising edge
// - reset   input   1   asynchronous, active-low reset
// - A       input   32  operand rs (dividend / multiplicand / mthi-mtlo data)
// - B       input   32  operand rt (divisor / multiplier)
// - MDUOp   input   4   0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu, 1001 msub, 1010 msubu
// - start   input   1   qualifies MDUOp; sampled on rising clk
// - busy    output  1   1 while an operation is in flight (registered)
// - HI      output  32  HI register
// - LO      output  32  LO register
// BEHAVIOUR
// - Reset (async, reset==0): HI=0, LO=0, busy=0, counter=0, state=IDLE, pending result cleared. Reset mid-operation aborts it; HI/LO stay 0.
// - FSM has two states, IDLE and BUSY.
// - IDLE with start=1 and op mult/multu/div/divu (or madd-family when enabled):
//   - compute the 64-bit result from A and B as sampled at that edge and latch it into pending {hi,lo};
//   - load counter with the op's CYCLES; go to BUSY; busy=1 from the next cycle.
// - BUSY:
//   - counter decrements every edge;
//   - on the edge where counter==1, write HI/LO from pending, set busy=0, return to IDLE.
//   - Net: busy is high for exactly N cycles, and the new HI/LO are visible in the first cycle after busy falls.
// - mthi/mtlo with start=1 in IDLE: write HI<=A or LO<=A at that edge. busy stays 0; the write is visible the next cycle.
// - start while busy=1: ignored; MDUOp/A/B are not sampled. The pipeline never issues this; the bench checks it is harmless.
// - start with MDUOp none or an undefined code: no effect.
// - Arithmetic rules:
//   - mult: {HI,LO} = $signed(A) * $signed(B), 64-bit. multu: unsigned 64-bit product.
//   - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of A.
//   - divu: unsigned quotient and remainder.
//   - Divide by zero (B==0): full DIV_CYCLES busy, but HI/LO are left unchanged at commit.
//   - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
// - HI/LO are not forwarded. Reads (mfhi/mflo) happen in IDLE only, enforced by the pipeline stall.
// CONFIGURATION
// - MDU_MADD_EN defined: opcodes 0111-1010 are legal, with MULT_CYCLES latency.
//   - madd/maddu: {HI,LO} <= {HI,LO} + product (signed/unsigned); msub/msubu: {HI,LO} <= {HI,LO} - product.
//   - 64-bit wrap-around; the accumulate uses HI/LO at commit time.
// - MDU_MADD_EN undefined: opcodes 0111-1010 behave as none (no busy, no write). The accumulate datapath is not built.
// TESTING
// - mult A=0xFFFFFFFE(-2) B=0x00000003, start 1 cycle -> busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA.
// - multu A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE LO=0x00000001.
// - div A=0xFFFFFFF9(-7) B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu with same operands -> LO=0x7FFFFFFC HI=1.
// - mthi A=0x12345678, then divu B=0 -> busy 10 cycles, HI stays 0x12345678 and LO stays at its prior value.
// - div started; pulse reset low at busy cycle 4 -> busy=0 HI=0 LO=0 immediately; a new start after release operates normally.
// - With MDU_MADD_EN: HI:LO=0x0:0xFFFFFFFF, maddu A=1 B=1 -> HI=1 LO=0. Without it: same stimulus -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The master drives the operation request; the slave returns busy and HI/LO.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDUOp, start, input busy, HI, LO);
  modport slave  (input A, B, MDUOp, start, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at start, committed after fixed latency.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate opcodes.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;

  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
  acc_t r_acc, w_acc_nxt;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [63:0]   r_pend;
  logic          r_skip;
  logic [31:0]   r_hi, r_lo;

  logic          w_load, w_commit;
  logic          w_is_mul, w_is_div;
  logic [63:0]   w_result, w_commit_val;
  logic [63:0]   w_prod_s, w_prod_u;
  logic [31:0]   w_bsafe, w_a_mag, w_b_mag;
  logic [31:0]   w_sq_mag, w_sr_mag, w_sq, w_sr;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'b0, bus.A} * {32'b0, bus.B};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no trap.
  assign w_bsafe  = (bus.B == '0) ? 32'd1 : bus.B;
  assign w_a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign w_b_mag  = w_bsafe[31] ? (~w_bsafe + 32'd1) : w_bsafe;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  assign w_sq     = (bus.A[31] ^ w_bsafe[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr     = bus.A[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_result = '0;
`ifdef MDU_MADD_EN
    w_acc_nxt = ACC_NONE;
`endif
    case (bus.MDUOp)
      OP_MULT:  begin w_is_mul = 1'b1; w_result = w_prod_s; end
      OP_MULTU: begin w_is_mul = 1'b1; w_result = w_prod_u; end
      OP_DIV:   begin w_is_div = 1'b1; w_result = {w_sr, w_sq}; end
      OP_DIVU:  begin w_is_div = 1'b1; w_result = {bus.A % w_bsafe, bus.A / w_bsafe}; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin w_is_mul = 1'b1; w_result = w_prod_s; w_acc_nxt = ACC_ADD; end
      OP_MADDU: begin w_is_mul = 1'b1; w_result = w_prod_u; w_acc_nxt = ACC_ADD; end
      OP_MSUB:  begin w_is_mul = 1'b1; w_result = w_prod_s; w_acc_nxt = ACC_SUB; end
      OP_MSUBU: begin w_is_mul = 1'b1; w_result = w_prod_u; w_acc_nxt = ACC_SUB; end
`endif
      default:  ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && (w_is_mul || w_is_div)) begin
          w_load      = 1'b1;
          w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef MDU_MADD_EN
    // Accumulate reads HI/LO at commit, not at start.
    case (r_acc)
      ACC_ADD: w_commit_val = {r_hi, r_lo} + r_pend;
      ACC_SUB: w_commit_val = {r_hi, r_lo} - r_pend;
      default: w_commit_val = r_pend;
    endcase
`else
    w_commit_val = r_pend;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_skip <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
`ifdef MDU_MADD_EN
      r_acc  <= ACC_NONE;
`endif
    end else begin
      if (w_load) begin
        r_pend <= w_result;
        r_skip <= w_is_div && (bus.B == '0);
`ifdef MDU_MADD_EN
        r_acc  <= w_acc_nxt;
`endif
      end
      if (w_commit) begin
        if (!r_skip) {r_hi, r_lo} <= w_commit_val;
      end else if (r_state == IDLE && bus.start) begin
        if (bus.MDUOp == OP_MTHI) r_hi <= bus.A;
        if (bus.MDUOp == OP_MTLO) r_lo <= bus.A;
      end
    end
  end

  assign bus.busy = (r_state == BUSY);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, arithmetic, HI/LO moves, ignored starts, reset abort.
module tb_mdu;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a rising edge; returns number of sampled busy cycles.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int cnt);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.MDUOp = 4'b0000;
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.MDUOp = '0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", bus.HI); end
    checks++; if (bus.LO !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", bus.LO); end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int cnt;
    run(4'b0001, 32'hFFFFFFFE, 32'h00000003, cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", cnt); end
    checks++; if (bus.HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.HI); end
    checks++; if (bus.LO !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", bus.LO); end
  endtask

  task automatic test_multu();
    int cnt;
    run(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", cnt); end
    checks++; if (bus.HI !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.HI); end
    checks++; if (bus.LO !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", bus.LO); end
  endtask

  task automatic test_div();
    int cnt;
    run(4'b0011, 32'hFFFFFFF9, 32'h00000002, cnt);
    checks++; if (cnt !== 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", cnt); end
    checks++; if (bus.LO !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", bus.LO); end
    checks++; if (bus.HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", bus.HI); end
    run(4'b0100, 32'hFFFFFFF9, 32'h00000002, cnt);
    checks++; if (cnt !== 10) begin failures++; $display("FAIL divu_busy got=%0d exp=10", cnt); end
    checks++; if (bus.LO !== 32'h7FFFFFFC) begin failures++; $display("FAIL divu_lo got=%h exp=7ffffffc", bus.LO); end
    checks++; if (bus.HI !== 32'h00000001) begin failures++; $display("FAIL divu_hi got=%h exp=00000001", bus.HI); end
  endtask

  task automatic test_div_overflow();
    int cnt;
    run(4'b0011, 32'h80000000, 32'hFFFFFFFF, cnt);
    checks++; if (cnt !== 10) begin failures++; $display("FAIL divovf_busy got=%0d exp=10", cnt); end
    checks++; if (bus.LO !== 32'h80000000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", bus.LO); end
    checks++; if (bus.HI !== 32'h00000000) begin failures++; $display("FAIL divovf_hi got=%h exp=00000000", bus.HI); end
  endtask

  task automatic test_mthi_divzero();
    int cnt;
    run(4'b0101, 32'h12345678, 32'h0, cnt);
    checks++; if (cnt !== 0) begin failures++; $display("FAIL mthi_busy got=%0d exp=0", cnt); end
    checks++; if (bus.HI !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", bus.HI); end
    run(4'b0100, 32'h00000055, 32'h0, cnt);
    checks++; if (cnt !== 10) begin failures++; $display("FAIL divz_busy got=%0d exp=10", cnt); end
    checks++; if (bus.HI !== 32'h12345678) begin failures++; $display("FAIL divz_hi got=%h exp=12345678", bus.HI); end
    checks++; if (bus.LO !== 32'h80000000) begin failures++; $display("FAIL divz_lo got=%h exp=80000000", bus.LO); end
  endtask

  task automatic test_mtlo();
    int cnt;
    run(4'b0110, 32'hCAFEBABE, 32'h0, cnt);
    checks++; if (cnt !== 0) begin failures++; $display("FAIL mtlo_busy got=%0d exp=0", cnt); end
    checks++; if (bus.LO !== 32'hCAFEBABE) begin failures++; $display("FAIL mtlo_lo got=%h exp=cafebabe", bus.LO); end
    checks++; if (bus.HI !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi got=%h exp=12345678", bus.HI); end
  endtask

  task automatic test_busy_ignore();
    int cnt;
    bus.MDUOp = 4'b0001; bus.A = 32'd3; bus.B = 32'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      bus.start = (cnt == 2 || cnt == 3);
      bus.MDUOp = (cnt == 2) ? 4'b0101 : 4'b0011;
      bus.A = 32'hDEADBEEF; bus.B = 32'h1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.MDUOp = 4'b0000;
    checks++; if (cnt !== 5) begin failures++; $display("FAIL ignore_busy got=%0d exp=5", cnt); end
    checks++; if (bus.HI !== 32'h0) begin failures++; $display("FAIL ignore_hi got=%h exp=00000000", bus.HI); end
    checks++; if (bus.LO !== 32'd12) begin failures++; $display("FAIL ignore_lo got=%h exp=0000000c", bus.LO); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_idle got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_undefined();
    int cnt;
    logic [3:0] ops [3];
    ops[0] = 4'b0000; ops[1] = 4'b1011; ops[2] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      run(ops[i], 32'hFFFF0000, 32'h3, cnt);
      checks++; if (cnt !== 0) begin failures++; $display("FAIL undef_busy op=%b got=%0d exp=0", ops[i], cnt); end
    end
    checks++; if (bus.HI !== 32'h0) begin failures++; $display("FAIL undef_hi got=%h exp=00000000", bus.HI); end
    checks++; if (bus.LO !== 32'd12) begin failures++; $display("FAIL undef_lo got=%h exp=0000000c", bus.LO); end
  endtask

  task automatic test_madd();
    int cnt;
    logic [31:0] exp_hi, exp_lo;
    int exp_cnt;
    run(4'b0101, 32'h0, 32'h0, cnt);
    run(4'b0110, 32'hFFFFFFFF, 32'h0, cnt);
    run(4'b1000, 32'h1, 32'h1, cnt);
`ifdef MDU_MADD_EN
    exp_cnt = 5; exp_hi = 32'h1; exp_lo = 32'h0;
`else
    exp_cnt = 0; exp_hi = 32'h0; exp_lo = 32'hFFFFFFFF;
`endif
    checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL maddu_busy got=%0d exp=%0d", cnt, exp_cnt); end
    checks++; if (bus.HI !== exp_hi) begin failures++; $display("FAIL maddu_hi got=%h exp=%h", bus.HI, exp_hi); end
    checks++; if (bus.LO !== exp_lo) begin failures++; $display("FAIL maddu_lo got=%h exp=%h", bus.LO, exp_lo); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    bus.MDUOp = 4'b0011; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_prebusy got=%0b exp=1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.HI !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=00000000", bus.HI); end
    checks++; if (bus.LO !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=00000000", bus.LO); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    run(4'b0001, 32'hFFFFFFFE, 32'h00000003, cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL rstmid_rerun_busy got=%0d exp=5", cnt); end
    checks++; if (bus.LO !== 32'hFFFFFFFA) begin failures++; $display("FAIL rstmid_rerun_lo got=%h exp=fffffffa", bus.LO); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    run(4'b0001, 32'd7, 32'd6, cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL b2b_first_busy got=%0d exp=5", cnt); end
    checks++; if (bus.LO !== 32'd42) begin failures++; $display("FAIL b2b_first_lo got=%h exp=0000002a", bus.LO); end
    run(4'b0010, 32'h00010000, 32'h00010000, cnt);
    checks++; if (cnt !== 5) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=5", cnt); end
    checks++; if (bus.HI !== 32'h1) begin failures++; $display("FAIL b2b_second_hi got=%h exp=00000001", bus.HI); end
    checks++; if (bus.LO !== 32'h0) begin failures++; $display("FAIL b2b_second_lo got=%h exp=00000000", bus.LO); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_mthi_divzero();
    test_mtlo();
    test_busy_ignore();
    test_undefined();
    test_madd();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
